// File: rtl/data_receiver.sv
// Serial-to-parallel receiver: recovers one 32-bit MSB-first word per frame using a
// 3-sample mid-bit majority vote, and hands it to the consumer on a valid/ack handshake.
module data_receiver #(
    parameter int unsigned BIT_CYCLES    = 100001,
    parameter int unsigned SAMPLE_OFFSET = 50000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rx_en,
    input  logic        d_in,
    input  logic        rx_ack,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_overrun,
    output logic        rx_busy
);

    localparam int unsigned CntW = $clog2(2 * BIT_CYCLES);

    // The counter tracks the frame edge number minus (bit index * BIT_CYCLES).
    // It therefore never exceeds BIT_CYCLES + SAMPLE_OFFSET + 1.
    localparam logic [CntW-1:0] SampFirst = CntW'(BIT_CYCLES + SAMPLE_OFFSET - 1);
    localparam logic [CntW-1:0] SampMid   = CntW'(BIT_CYCLES + SAMPLE_OFFSET);
    localparam logic [CntW-1:0] SampLast  = CntW'(BIT_CYCLES + SAMPLE_OFFSET + 1);
    localparam logic [CntW-1:0] NextBit   = CntW'(SAMPLE_OFFSET + 2);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cyc_q, cyc_d;
    logic [4:0]      bit_q, bit_d;
    logic [31:0]     shift_q, shift_d;
    logic            s0_q, s0_d;
    logic            s1_q, s1_d;
    logic [31:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic            busy_q;
    logic            maj;
    logic [31:0]     word;

    assign maj  = (s0_q & s1_q) | (s0_q & d_in) | (s1_q & d_in);
    assign word = {shift_q[30:0], maj};

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (valid_q && rx_ack) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                bit_d = 5'd0;
                // The enabling edge is frame edge 0, so the next edge is edge 1.
                cyc_d = rx_en ? CntW'(1) : '0;
                if (rx_en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!rx_en) begin
                    state_d = StIdle;
                    cyc_d   = '0;
                    bit_d   = 5'd0;
                end else begin
                    cyc_d = cyc_q + CntW'(1);
                    if (cyc_q == SampFirst) begin
                        s0_d = d_in;
                    end
                    if (cyc_q == SampMid) begin
                        s1_d = d_in;
                    end
                    if (cyc_q == SampLast) begin
                        shift_d = word;
                        bit_d   = bit_q + 5'd1;
                        cyc_d   = NextBit;
                        if (bit_q == 5'd31) begin
                            state_d = StDone;
                            cyc_d   = '0;
                            if (!valid_q || rx_ack) begin
                                data_d  = word;
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end
                    end
                end
            end
            StDone: begin
                cyc_d = '0;
                bit_d = 5'd0;
                if (!rx_en) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            bit_q   <= 5'd0;
            shift_q <= 32'h0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_overrun = ovr_q;
    assign rx_busy    = busy_q;

endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver at BIT_CYCLES=8, SAMPLE_OFFSET=4: table of frames plus
// hand-written abort, mid-frame reset and held-enable sequences.
module tb_data_receiver;

    localparam int unsigned B = 8;
    localparam int unsigned O = 4;
    localparam int          DoneEdge = 32 * B + O + 1;  // 261

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rx_en = 1'b0;
    logic        d_in = 1'b1;
    logic        rx_ack = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_overrun;
    logic        rx_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] prev_data;
    logic        prev_valid;

    data_receiver #(
        .BIT_CYCLES   (B),
        .SAMPLE_OFFSET(O)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .rx_en     (rx_en),
        .d_in      (d_in),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_overrun(rx_overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_before;
        logic [31:0] word;
        bit          glitch;
        bit          ack_done;
        bit          ack_after;
        logic [31:0] exp_data;
        logic        exp_valid;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic do_reset();
        nrst   = 1'b1;
        rx_en  = 1'b0;
        rx_ack = 1'b0;
        d_in   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        prev_data  = 32'h0;
        prev_valid = 1'b0;
    endtask

    // Drives frame edges 0..last; abort_at >= 0 drops rx_en at that edge instead.
    task automatic run_frame(input logic [31:0] w, input bit glitch, input bit ack_done,
                             input int abort_at);
        int  last;
        int  k;
        bit  busy_ok;
        busy_ok = 1'b1;
        last    = (abort_at >= 0) ? abort_at : DoneEdge;
        for (int e = 0; e <= last; e++) begin
            k      = e / B - 1;
            rx_en  = (e != abort_at);
            d_in   = (k >= 0 && k < 32) ? w[31-k] : 1'b1;
            if (glitch && k >= 0 && k < 32 && e == (k + 1) * B + O) d_in = 1'b0;
            rx_ack = ack_done && (e == DoneEdge);
            @(posedge clk);
            @(negedge clk);
            if (e != abort_at && rx_busy !== 1'b1) busy_ok = 1'b0;
            if (e == DoneEdge - 1) begin
                check("data_before_done", rx_data, prev_data);
                check("valid_before_done", {31'h0, rx_valid}, {31'h0, prev_valid});
            end
        end
        rx_ack = 1'b0;
        check("busy_during_frame", {31'h0, busy_ok}, 32'h1);
    endtask

    task automatic drop_en(input bit ack);
        rx_en  = 1'b0;
        rx_ack = ack;
        d_in   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rx_ack = 1'b0;
        d_in   = 1'b1;
        check("busy_after_drop", {31'h0, rx_busy}, 32'h0);
    endtask

    initial begin
        int rises;
        logic last_valid;

        vecs[0] = '{1'b1, 32'hA5C3_0F96, 1'b0, 1'b0, 1'b1, 32'hA5C3_0F96, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};

        @(negedge clk);
        do_reset();
        check("reset_data", rx_data, 32'h0);
        check("reset_flags", {29'h0, rx_valid, rx_overrun, rx_busy}, 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            run_frame(vecs[i].word, vecs[i].glitch, vecs[i].ack_done, -1);
            check($sformatf("v%0d_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("v%0d_valid", i), {31'h0, rx_valid}, {31'h0, vecs[i].exp_valid});
            check($sformatf("v%0d_overrun", i), {31'h0, rx_overrun}, {31'h0, vecs[i].exp_ovr});
            drop_en(vecs[i].ack_after);
            if (vecs[i].ack_after) begin
                check($sformatf("v%0d_valid_cleared", i), {31'h0, rx_valid}, 32'h0);
            end
            prev_data  = vecs[i].exp_data;
            prev_valid = vecs[i].exp_valid && !vecs[i].ack_after;
        end

        // Abort just after bit 10 has been shifted in.
        do_reset();
        run_frame(32'h0000_0001, 1'b0, 1'b0, 11 * B + O + 2);
        check("abort_busy", {31'h0, rx_busy}, 32'h0);
        check("abort_valid", {31'h0, rx_valid}, 32'h0);
        check("abort_data", rx_data, 32'h0);
        run_frame(32'h0000_0001, 1'b0, 1'b0, -1);
        check("after_abort_data", rx_data, 32'h0000_0001);
        check("after_abort_valid", {31'h0, rx_valid}, 32'h1);
        drop_en(1'b0);

        // Reset in the middle of bit 20 while a word is pending.
        rx_en = 1'b1;
        for (int e = 0; e < 21 * B + 2; e++) begin
            d_in = e[0];
            @(posedge clk);
            @(negedge clk);
        end
        do_reset();
        check("midreset_data", rx_data, 32'h0);
        check("midreset_flags", {29'h0, rx_valid, rx_overrun, rx_busy}, 32'h0);

        // Enable held high for a frame plus three more frame lengths, acking continuously.
        rises      = 0;
        last_valid = 1'b0;
        rx_ack     = 1'b1;
        rx_en      = 1'b1;
        for (int e = 0; e < 4 * (DoneEdge + 3); e++) begin
            d_in = (e / B) % 3 == 0;
            @(posedge clk);
            @(negedge clk);
            if (rx_valid && !last_valid) rises++;
            last_valid = rx_valid;
        end
        check("held_en_valid_rises", rises, 1);
        check("held_en_busy", {31'h0, rx_busy}, 32'h1);
        check("held_en_overrun", {31'h0, rx_overrun}, 32'h0);
        rx_ack = 1'b0;
        drop_en(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
